// File: rtl/mem_port.sv
// rtl/mem_port.sv - single-outstanding memory port with MAR/MDR for a simple CPU datapath.
// Optional request timeout with ERR state when MEM_PORT_TIMEOUT_EN is defined.
module mem_port #(
    parameter int BITS    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ld_mar,
    input  logic [BITS-1:0] i_addr,
    input  logic            i_rd,
    input  logic            i_wr,
    input  logic [BITS-1:0] i_wdata,
    output logic [BITS-1:0] o_mar,
    output logic [BITS-1:0] o_mdr,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [BITS-1:0] o_mem_addr,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [BITS-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [BITS-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
`ifdef MEM_PORT_TIMEOUT_EN
        ,
        S_ERR
`endif
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [BITS-1:0] mar;
    logic [BITS-1:0] mdr;
    logic [BITS-1:0] wdata_q;
    logic            cmd_we;

    logic            busy;
    logic            done;
    logic            err;
    logic            mem_req;
    logic            mem_we;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0]   wait_cnt;
    logic            timed_out;

    assign timed_out = !i_mem_ack && (wait_cnt == CNT_LAST);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_rd || i_wr) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = cmd_we;
                if (i_mem_ack) begin
                    state_next = S_DONE;
                end
`ifdef MEM_PORT_TIMEOUT_EN
                else if (timed_out) begin
                    state_next = S_ERR;
                end
`endif
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
`ifdef MEM_PORT_TIMEOUT_EN
            S_ERR: begin
                busy       = 1'b1;
                err        = 1'b1;
                state_next = S_IDLE;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // MAR and command/data latch only move in IDLE, so they stay frozen for a whole transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mar     <= '0;
            mdr     <= '0;
            wdata_q <= '0;
            cmd_we  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_ld_mar) begin
                        mar <= i_addr;
                    end
                    if (i_rd || i_wr) begin
                        cmd_we  <= i_wr;
                        wdata_q <= i_wdata;
                    end
                end
                S_REQ: begin
                    if (i_mem_ack && !cmd_we) begin
                        mdr <= i_mem_rdata;
                    end
                end
`ifdef MEM_PORT_TIMEOUT_EN
                S_ERR: begin
                    mdr <= '1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_PORT_TIMEOUT_EN
    // Cleared while idle so every transaction starts counting from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if (state == S_REQ) begin
            if (!i_mem_ack && !timed_out) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    assign o_mar       = mar;
    assign o_mdr       = mdr;
    assign o_busy      = busy;
    assign o_done      = done;
`ifdef MEM_PORT_TIMEOUT_EN
    assign o_err       = err;
`else
    assign o_err       = 1'b0;
`endif
    assign o_mem_addr  = mar;
    assign o_mem_req   = mem_req;
    assign o_mem_we    = mem_we;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - directed self-checking bench for mem_port.
module tb_mem_port;

    localparam int BITS = 8;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_ld_mar;
    logic [BITS-1:0] i_addr;
    logic            i_rd;
    logic            i_wr;
    logic [BITS-1:0] i_wdata;
    logic [BITS-1:0] o_mar;
    logic [BITS-1:0] o_mdr;
    logic            o_busy;
    logic            o_done;
    logic            o_err;
    logic [BITS-1:0] o_mem_addr;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [BITS-1:0] o_mem_wdata;
    logic            i_mem_ack;
    logic [BITS-1:0] i_mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    always #5 i_clk = ~i_clk;

    mem_port #(.BITS(BITS), .TIMEOUT(15)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ld_mar    (i_ld_mar),
        .i_addr      (i_addr),
        .i_rd        (i_rd),
        .i_wr        (i_wr),
        .i_wdata     (i_wdata),
        .o_mar       (o_mar),
        .o_mdr       (o_mdr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        i_ld_mar = 1'b0;
        i_addr   = '0;
        i_rd     = 1'b0;
        i_wr     = 1'b0;
        i_wdata  = '0;
    endtask

    initial begin
        clear_in();
        i_rst       = 1'b1;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        step();
        step();
        i_rst = 1'b0;

        chk("rst_busy", o_busy, 0);
        chk("rst_mar", o_mar, 0);
        chk("rst_mdr", o_mdr, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);

        // Read of 0x10 with zero-wait ack
        i_ld_mar = 1'b1; i_addr = 8'h10;
        step();
        clear_in();
        chk("rd_mar", o_mar, 8'h10);
        chk("rd_idle_busy", o_busy, 0);
        i_rd = 1'b1;
        step();
        clear_in();
        chk("rd_req", o_mem_req, 1);
        chk("rd_we", o_mem_we, 0);
        chk("rd_addr", o_mem_addr, 8'h10);
        chk("rd_busy", o_busy, 1);
        i_mem_ack = 1'b1; i_mem_rdata = 8'h3C;
        step();
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        chk("rd_done", o_done, 1);
        chk("rd_mdr", o_mdr, 8'h3C);
        chk("rd_done_req", o_mem_req, 0);
        chk("rd_done_busy", o_busy, 1);
        chk("rd_done_we", o_mem_we, 0);
        step();
        chk("rd_idle_done", o_done, 0);
        chk("rd_idle_busy2", o_busy, 0);
        chk("rd_mdr_hold", o_mdr, 8'h3C);

        // Write to 0x20 (MAR load in the same cycle), ack after 3 wait cycles
        i_ld_mar = 1'b1; i_addr = 8'h20; i_wr = 1'b1; i_wdata = 8'hA5;
        step();
        clear_in();
        chk("wr_mar", o_mar, 8'h20);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_req", o_mem_req, 1);
            chk("wr_wdata", o_mem_wdata, 8'hA5);
            if (o_mem_we === 1'b1) cnt++;
            if (i == 3) i_mem_ack = 1'b1;
            step();
        end
        i_mem_ack = 1'b0;
        chk("wr_we_cycles", cnt, 4);
        chk("wr_done", o_done, 1);
        chk("wr_mdr_unchanged", o_mdr, 8'h3C);
        chk("wr_done_we", o_mem_we, 0);
        step();
        chk("wr_idle_busy", o_busy, 0);

        // Busy protection: MAR load and write strobe during pending read are ignored
        i_ld_mar = 1'b1; i_addr = 8'h10; i_rd = 1'b1;
        step();
        clear_in();
        i_ld_mar = 1'b1; i_addr = 8'h55; i_wr = 1'b1; i_wdata = 8'h77;
        step();
        chk("bp_req", o_mem_req, 1);
        chk("bp_addr", o_mem_addr, 8'h10);
        chk("bp_we", o_mem_we, 0);
        i_mem_ack = 1'b1; i_mem_rdata = 8'h5A;
        step();
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        clear_in();
        chk("bp_done", o_done, 1);
        chk("bp_mdr", o_mdr, 8'h5A);
        chk("bp_mar", o_mar, 8'h10);
        step();
        chk("bp_idle_busy", o_busy, 0);
        step();
        chk("bp_no_second_req", o_mem_req, 0);
        chk("bp_mar_hold", o_mar, 8'h10);

        // Ack outside REQ is ignored
        i_mem_ack = 1'b1; i_mem_rdata = 8'h99;
        step();
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        chk("stray_ack_mdr", o_mdr, 8'h5A);
        chk("stray_ack_done", o_done, 0);
        chk("stray_ack_busy", o_busy, 0);

        // Simultaneous rd+wr: write wins; then reset aborts in REQ
        i_rd = 1'b1; i_wr = 1'b1; i_wdata = 8'hC3;
        step();
        clear_in();
        chk("rw_we", o_mem_we, 1);
        chk("rw_wdata", o_mem_wdata, 8'hC3);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("abort_req", o_mem_req, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_mar", o_mar, 0);
        chk("abort_done", o_done, 0);
        chk("abort_mdr", o_mdr, 0);
        chk("abort_wdata", o_mem_wdata, 0);
        i_mem_ack = 1'b1; i_mem_rdata = 8'hEE;
        step();
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        chk("late_ack_done", o_done, 0);
        chk("late_ack_mdr", o_mdr, 0);

        // Reset has priority over a start strobe
        i_rst = 1'b1; i_rd = 1'b1; i_ld_mar = 1'b1; i_addr = 8'h44;
        step();
        clear_in();
        i_rst = 1'b0;
        chk("rst_prio_busy", o_busy, 0);
        chk("rst_prio_mar", o_mar, 0);

        // Read with no ack
        i_ld_mar = 1'b1; i_addr = 8'h30; i_rd = 1'b1;
        step();
        clear_in();
`ifdef MEM_PORT_TIMEOUT_EN
        cnt = 0;
        while (o_mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        chk("to_req_cycles", cnt, 15);
        chk("to_err", o_err, 1);
        chk("to_done", o_done, 0);
        chk("to_mdr", o_mdr, 8'hFF);
        step();
        chk("to_idle_busy", o_busy, 0);
        chk("to_err_pulse", o_err, 0);
`else
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_mem_req === 1'b1 && o_err === 1'b0) cnt++;
            step();
        end
        chk("noto_req_held", cnt, 40);
        chk("noto_busy", o_busy, 1);
        chk("noto_err", o_err, 0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("noto_rst_req", o_mem_req, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
